// File: rtl/spi_packet_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : spi_packet_decoder
//  Description : Assembles 4-byte SPI packets (brush/colour/x/y) into
//                pixel-write commands, range-checks the coordinates against
//                the active VGA area and presents one command at a time on a
//                valid/ready interface.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   pixel clock (only clock)
//    reset_n      in   asynchronous active-low reset
//    frame_active in   SPI chip-select active, synchronous to clk
//    byte_valid   in   one-cycle strobe qualifying byte_data
//    byte_data    in   [7:0] received SPI byte
//    wr_valid     out  command pending in the output slot
//    wr_ready     in   pixel store accepts the command this cycle
//    wr_x         out  [9:0] x coordinate
//    wr_y         out  [9:0] y coordinate
//    wr_color     out  [2:0] colour code
//    wr_brush     out  brush enable
//    drop_cnt     out  [7:0] saturating count of discarded packets
//    busy         out  FSM is part-way through a packet
// ============================================================================
module spi_packet_decoder #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_active,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       wr_valid,
  input  logic       wr_ready,
  output logic [9:0] wr_x,
  output logic [9:0] wr_y,
  output logic [2:0] wr_color,
  output logic       wr_brush,
  output logic [7:0] drop_cnt,
  output logic       busy
);

  localparam logic [10:0] H_LIM = 11'(H_ACTIVE);
  localparam logic [10:0] V_LIM = 11'(V_ACTIVE);
  localparam logic [1:0]  SYNC  = 2'b10;

  typedef enum logic [1:0] {
    S_HDR = 2'd0,
    S_XLO = 2'd1,
    S_YHI = 2'd2,
    S_YLO = 2'd3
  } state_t;

  state_t     state;
  state_t     state_next;

  // Fields captured from the first three bytes of the packet in flight
  logic       hdr_brush;
  logic [2:0] hdr_color;
  logic [1:0] x_hi;
  logic [7:0] x_lo;
  logic [1:0] y_hi;

  logic       take;
  logic [9:0] pkt_x;
  logic [9:0] pkt_y;
  logic       in_range;
  logic       load;
  logic       drop;

  // Bytes are only honoured while the frame is active; an abort wins over
  // a byte arriving in the same cycle.
  assign take  = frame_active & byte_valid;
  // y low byte is used straight off the bus so the command loads at the B3 edge
  assign pkt_x = {x_hi, x_lo};
  assign pkt_y = {y_hi, byte_data};
  assign in_range = ({1'b0, pkt_x} < H_LIM) && ({1'b0, pkt_y} < V_LIM);

  // --------------------------------------------------------------------------
  // Next-state / control
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    load       = 1'b0;
    drop       = 1'b0;
    if (!frame_active) begin
      state_next = S_HDR;
    end else if (byte_valid) begin
      unique case (state)
        S_HDR: begin
          if (byte_data[7:6] == SYNC) state_next = S_XLO;
          else                         drop       = 1'b1;
        end
        S_XLO: state_next = S_YHI;
        S_YHI: state_next = S_YLO;
        S_YLO: begin
          state_next = S_HDR;
          if (!in_range) begin
            drop = 1'b1;
          end else if (!wr_valid || wr_ready) begin
            // Slot is empty or being drained at this very edge
            load = 1'b1;
          end else begin
            drop = 1'b1;
          end
        end
        default: state_next = S_HDR;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // State, busy and packet field capture
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_HDR;
      busy      <= 1'b0;
      hdr_brush <= 1'b0;
      hdr_color <= 3'd0;
      x_hi      <= 2'd0;
      x_lo      <= 8'd0;
      y_hi      <= 2'd0;
    end else begin
      state <= state_next;
      busy  <= (state_next != S_HDR);
      if (take) begin
        unique case (state)
          S_HDR: begin
            hdr_brush <= byte_data[5];
            hdr_color <= byte_data[4:2];
            x_hi      <= byte_data[1:0];
          end
          S_XLO:   x_lo <= byte_data;
          S_YHI:   y_hi <= byte_data[1:0];
          default: ;
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output slot: fields change only when a new command loads, so they hold
  // steady for as long as wr_valid is up and the sink stalls.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_valid <= 1'b0;
      wr_x     <= 10'd0;
      wr_y     <= 10'd0;
      wr_color <= 3'd0;
      wr_brush <= 1'b0;
    end else begin
      if (load) begin
        wr_valid <= 1'b1;
        wr_x     <= pkt_x;
        wr_y     <= pkt_y;
        wr_color <= hdr_color;
        wr_brush <= hdr_brush;
      end else if (wr_valid && wr_ready) begin
        wr_valid <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Discard counter, saturating at 255
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_cnt <= 8'd0;
    end else if (drop && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_packet_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_packet_decoder
//  Description : Self-checking bench for spi_packet_decoder. A byte-queue
//                reference model predicts accepted commands (scoreboard
//                queue), slot occupancy, busy and the discard count; a
//                negedge monitor compares the DUT against it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_packet_decoder;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       frame_active = 1'b0;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_data = 8'd0;
  logic       wr_ready = 1'b0;
  logic       wr_valid;
  logic [9:0] wr_x;
  logic [9:0] wr_y;
  logic [2:0] wr_color;
  logic       wr_brush;
  logic [7:0] drop_cnt;
  logic       busy;

  spi_packet_decoder #(.H_ACTIVE(640), .V_ACTIVE(480)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .frame_active (frame_active),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_x         (wr_x),
    .wr_y         (wr_y),
    .wr_color     (wr_color),
    .wr_brush     (wr_brush),
    .drop_cnt     (drop_cnt),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] c;
    logic       b;
  } cmd_t;

  int   errors = 0;
  int   checks = 0;
  logic mon_on = 1'b0;

  // Reference model state
  cmd_t       exp_q[$];
  logic [7:0] m_pkt[$];
  logic       m_full = 1'b0;
  int         m_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_pkt.delete();
    m_full = 1'b0;
    m_cnt  = 0;
  endtask

  // Behaviour of one clock edge given the inputs presented to it
  task automatic model_step(input logic fa, input logic bv, input logic [7:0] bd, input logic rdy);
    logic xfer;
    logic loaded;
    int   x;
    int   y;
    xfer   = m_full && rdy;
    loaded = 1'b0;
    if (!fa) begin
      m_pkt.delete();
    end else if (bv) begin
      if (m_pkt.size() == 0 && bd[7:6] != 2'b10) begin
        if (m_cnt < 255) m_cnt++;
      end else begin
        m_pkt.push_back(bd);
      end
      if (m_pkt.size() == 4) begin
        x = m_pkt[0][1:0] * 256 + m_pkt[1];
        y = m_pkt[2][1:0] * 256 + m_pkt[3];
        if (x >= 640 || y >= 480 || (m_full && !xfer)) begin
          if (m_cnt < 255) m_cnt++;
        end else begin
          exp_q.push_back('{x: 10'(x), y: 10'(y), c: m_pkt[0][4:2], b: m_pkt[0][5]});
          loaded = 1'b1;
        end
        m_pkt.delete();
      end
    end
    if (loaded)    m_full = 1'b1;
    else if (xfer) m_full = 1'b0;
  endtask

  // Drive one cycle; called at posedge+2
  task automatic cycle(input logic fa, input logic bv, input logic [7:0] bd, input logic rdy);
    frame_active = fa;
    byte_valid   = bv;
    byte_data    = bd;
    wr_ready     = rdy;
    @(posedge clk);
    model_step(fa, bv, bd, rdy);
    #2;
  endtask

  task automatic send_pkt(input logic [31:0] p, input logic rdy_body, input logic rdy_last);
    cycle(1'b1, 1'b1, p[31:24], rdy_body);
    cycle(1'b1, 1'b1, p[23:16], rdy_body);
    cycle(1'b1, 1'b1, p[15:8],  rdy_body);
    cycle(1'b1, 1'b1, p[7:0],   rdy_last);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 8'h00, rdy);
  endtask

  // Monitor: outputs after the previous edge, inputs for the next edge
  always @(negedge clk) begin
    cmd_t got;
    cmd_t want;
    if (mon_on && reset_n) begin
      check("wr_valid", {31'd0, wr_valid}, {31'd0, m_full});
      check("busy", {31'd0, busy}, {31'd0, (m_pkt.size() != 0)});
      check("drop_cnt", {24'd0, drop_cnt}, 32'(m_cnt));
      if (wr_valid && wr_ready) begin
        got = '{x: wr_x, y: wr_y, c: wr_color, b: wr_brush};
        if (exp_q.size() == 0) begin
          check("unexpected_cmd", {7'd0, got}, 32'hFFFF_FFFF);
        end else begin
          want = exp_q.pop_front();
          check("cmd", {7'd0, got}, {7'd0, want});
        end
      end
    end
  end

  initial begin
    int         x;
    int         y;
    logic [7:0] b0;
    logic [31:0] p;
    // Reset values
    #1;
    check("rst_wr_valid", {31'd0, wr_valid}, 32'd0);
    check("rst_wr_x", {22'd0, wr_x}, 32'd0);
    check("rst_wr_y", {22'd0, wr_y}, 32'd0);
    check("rst_wr_color", {29'd0, wr_color}, 32'd0);
    check("rst_wr_brush", {31'd0, wr_brush}, 32'd0);
    check("rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #2;
    reset_n = 1'b1;
    mon_on  = 1'b1;
    idle(2, 1'b1);

    // Basic decode: x=320 y=300 colour=1 brush=1
    send_pkt(32'hA540_012C, 1'b1, 1'b1);
    check("t1_valid_after_b3", {31'd0, wr_valid}, 32'd1);
    check("t1_x", {22'd0, wr_x}, 32'd320);
    check("t1_y", {22'd0, wr_y}, 32'd300);
    idle(2, 1'b1);
    check("t1_drop", {24'd0, drop_cnt}, 32'd0);

    // Bad sync byte then a good packet
    cycle(1'b1, 1'b1, 8'h45, 1'b1);
    send_pkt(32'hBC12_0034, 1'b1, 1'b1);
    idle(2, 1'b1);
    check("t2_drop", {24'd0, drop_cnt}, 32'd1);

    // Range boundary: x=640 dropped, x=639 y=479 accepted
    send_pkt(32'h8280_000A, 1'b1, 1'b1);
    idle(2, 1'b1);
    check("t3_drop_oob", {24'd0, drop_cnt}, 32'd2);
    send_pkt(32'h827F_01DF, 1'b1, 1'b1);
    idle(2, 1'b1);
    check("t3_drop_inb", {24'd0, drop_cnt}, 32'd2);
    send_pkt(32'h8001_01E0, 1'b1, 1'b1);   // y=480
    idle(2, 1'b1);
    check("t3_drop_y", {24'd0, drop_cnt}, 32'd3);

    // Backpressure: hold, overflow, then refill on the draining edge
    send_pkt(32'hA001_0002, 1'b0, 1'b0);
    idle(3, 1'b0);
    send_pkt(32'hA403_0004, 1'b0, 1'b0);
    idle(2, 1'b0);
    check("t4_held_x", {22'd0, wr_x}, 32'd1);
    check("t4_drop", {24'd0, drop_cnt}, 32'd4);
    send_pkt(32'hBD05_0106, 1'b0, 1'b1);
    check("t4_refill_valid", {31'd0, wr_valid}, 32'd1);
    check("t4_refill_x", {22'd0, wr_x}, 32'h105);
    idle(2, 1'b1);

    // Abort after B1, then a full packet
    cycle(1'b1, 1'b1, 8'h81, 1'b1);
    cycle(1'b1, 1'b1, 8'h11, 1'b1);
    cycle(1'b0, 1'b1, 8'h01, 1'b1);     // abort beats the byte
    send_pkt(32'h8C22_0133, 1'b1, 1'b1);
    idle(2, 1'b1);
    check("t5_drop", {24'd0, drop_cnt}, 32'd4);

    // Asynchronous reset while a command is pending and FSM is in S_YHI
    send_pkt(32'hA010_0020, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 8'h80, 1'b0);
    cycle(1'b1, 1'b1, 8'h05, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_wr_valid", {31'd0, wr_valid}, 32'd0);
    check("arst_wr_x", {22'd0, wr_x}, 32'd0);
    check("arst_wr_y", {22'd0, wr_y}, 32'd0);
    check("arst_wr_color", {29'd0, wr_color}, 32'd0);
    check("arst_wr_brush", {31'd0, wr_brush}, 32'd0);
    check("arst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    model_reset();
    byte_valid = 1'b0;
    @(posedge clk); #2;
    reset_n = 1'b1;
    send_pkt(32'hB432_0145, 1'b1, 1'b1);
    idle(2, 1'b1);

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      x  = $urandom_range(0, 720);
      y  = $urandom_range(0, 540);
      b0 = {(($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : 2'b10),
            1'($urandom), 3'($urandom), 2'(x >> 8)};
      p  = {b0, 8'(x), 6'($urandom), 2'(y >> 8), 8'(y)};
      for (int k = 0; k < 4; k++) begin
        for (int g = $urandom_range(0, 2); g > 0; g--)
          cycle(($urandom_range(0, 30) != 0), 1'($urandom_range(0, 5) == 0),
                8'($urandom), ($urandom_range(0, 3) != 0));
        cycle(($urandom_range(0, 40) != 0), 1'b1, p[31 - 8*k -: 8],
              ($urandom_range(0, 3) != 0));
      end
    end
    idle(4, 1'b1);

    // Saturation of the discard counter
    for (int n = 0; n < 270; n++) cycle(1'b1, 1'b1, 8'h00, 1'b1);
    check("sat_drop", {24'd0, drop_cnt}, 32'd255);
    send_pkt(32'h8000_0000, 1'b1, 1'b1);
    idle(4, 1'b1);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    mon_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
